bist_fail_logger: RTL
=====================

// Module: bist_fail_logger
// PURPOSE
// - Downstream of the BIST comparator: consumes its gt/eq/lt result per compared word during a march test.
// - On every mismatch, captures {address, expected, actual, direction} into a small FIFO for readout by the host/TAP.
// - Keeps a saturating fail counter, a sticky overflow flag and the final pass/fail verdict.
// PARAMETERS
// - DATA_W    8  width of expected/actual data (matches comparator operands)
// - ADDR_W    6  memory address width
// - LOG_DEPTH 4  fail-log FIFO entries; power of two, >=2
// - CNT_W     8  fail counter width; saturates at 2**CNT_W-1
// PORTS
// - clk        in   1       BIST clock
// - rst_n      in   1       async active-low reset
// - start      in   1       pulse: clear log/counters, begin test
// - end_test   in   1       pulse: march sequence finished
// - cmp_valid  in   1       comparator outputs valid this cycle
// - cmp_addr   in   ADDR_W  address of the word being compared
// - data_t     in   DATA_W  expected data fed to comparator
// - ramout     in   DATA_W  actual memory data fed to comparator
// - gt, eq, lt in   1 each  comparator result
// - log_rd     in   1       pop one log entry (ignored when log empty)
// - log_valid  out  1       log head entry valid (FIFO not empty)
// - log_addr   out  ADDR_W  head entry address
// - log_exp    out  DATA_W  head entry expected data
// - log_act    out  DATA_W  head entry actual data
// - log_gt     out  1       head entry direction: 1 = expected>actual, 0 = expected<actual
// - fail_cnt   out  CNT_W   total mismatches this test (saturating)
// - overflow   out  1       sticky: a fail was dropped because log full
// - busy       out  1       FSM in ACTIVE
// - done       out  1       FSM in DONE
// - pass       out  1       done && fail_cnt==0 && !overflow
// BEHAVIOUR
// - Reset: FSM IDLE; FIFO empty; all outputs 0 (log_* data fields 0).
// - FSM IDLE -start-> ACTIVE -end_test-> DONE -start-> ACTIVE. end_test in IDLE/DONE ignored.
// - start in any state (incl. ACTIVE): next cycle FIFO empty, fail_cnt=0, overflow=0, state ACTIVE.
// - start and end_test same cycle: start wins.
// - Fail event = ACTIVE && cmp_valid && !eq. cmp_valid outside ACTIVE ignored.
// - Invalid result (eq with gt|lt, or none of gt/eq/lt set) with cmp_valid counts as fail, log_gt=0.
// - Fail: fail_cnt+1 (hold at max); entry written next edge; log_valid visible 1 cycle after fail.
// - FIFO full on fail with no pop same cycle: entry dropped, overflow set, fail_cnt still increments.
// - FIFO full, fail and log_rd same cycle: pop head and push new entry; no overflow.
// - log_rd reads allowed in any state; head outputs registered, update the cycle after pop.
// - Pointers ADDR width log2(LOG_DEPTH)+1; wrap modulo LOG_DEPTH; full = MSB differ, rest equal.
// - pass/done asserted from the cycle after end_test until next start or reset.
// - Async reset mid-test: immediate clear to reset values; log contents lost.
// CONFIGURATION
// - Macro BIST_STOP_ON_FAIL_EN.
// - Defined: extra output halt_req (1 bit, reset 0); set the cycle after the first fail event in ACTIVE;
//   FSM goes straight to DONE on that same edge; halt_req cleared by start. Later cmp_valid ignored.
// - Not defined: no halt_req port; test runs to end_test, logging all fails.
// TESTING
// - Reset, start, 64 cmp_valid with eq=1, end_test -> done=1, pass=1, fail_cnt=0, log_valid=0.
// - Fail at addr 0x05, data_t=0xAA, ramout=0x55, gt=1 -> next cycle log_valid=1, log_addr=0x05,
//   log_exp=0xAA, log_act=0x55, log_gt=1, fail_cnt=1; after end_test pass=0.
// - 6 fails, no reads, LOG_DEPTH=4 -> fail_cnt=6, overflow=1, 4 entries popped in order, then log_valid=0.
// - FIFO full + fail + log_rd same cycle -> overflow=0, oldest entry gone, new entry at tail.
// - start during ACTIVE with 3 logged fails -> next cycle fail_cnt=0, log_valid=0, busy=1.
// - BIST_STOP_ON_FAIL_EN: first fail at addr 0x10 -> halt_req=1, done=1, later fails not counted (fail_cnt=1).

Source files
------------

// File: rtl/bist_fail_logger.sv
// BIST fail logger: captures comparator mismatches into a small FIFO, counts fails, reports verdict.
// Optional macro BIST_STOP_ON_FAIL_EN adds halt_req and ends the test on the first fail.
module bist_fail_logger #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned LOG_DEPTH = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              end_test,
  input  logic              cmp_valid,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [DATA_W-1:0] data_t,
  input  logic [DATA_W-1:0] ramout,
  input  logic              gt,
  input  logic              eq,
  input  logic              lt,
  input  logic              log_rd,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_exp,
  output logic [DATA_W-1:0] log_act,
  output logic              log_gt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              overflow,
  output logic              busy,
  output logic              done,
`ifdef BIST_STOP_ON_FAIL_EN
  output logic              halt_req,
`endif
  output logic              pass
);

  localparam int unsigned IDX_W = $clog2(LOG_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] mem_addr [LOG_DEPTH];
  logic [DATA_W-1:0] mem_exp  [LOG_DEPTH];
  logic [DATA_W-1:0] mem_act  [LOG_DEPTH];
  logic              mem_gt   [LOG_DEPTH];

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;
  logic             fail_ev, res_ok, entry_gt;
  logic             empty, full, empty_d, pop, push;
  logic [IDX_W-1:0] rd_idx_d, wr_idx;

  logic              head_valid_d;
  logic [ADDR_W-1:0] head_addr_d;
  logic [DATA_W-1:0] head_exp_d;
  logic [DATA_W-1:0] head_act_d;
  logic              head_gt_d;
  logic              busy_d, done_d, pass_d;
  logic              halt_d;
  logic              halt_q;

  // Comparator decode: only a lone eq is a pass; any other combination is a fail.
  always_comb begin
    res_ok   = eq && !gt && !lt;
    entry_gt = gt && !eq && !lt;
    fail_ev  = (state_q == ST_ACTIVE) && cmp_valid && !res_ok;
  end

  // FSM next state; start has priority over everything else.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_ACTIVE;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (end_test) begin
            state_d = ST_DONE;
          end
`ifdef BIST_STOP_ON_FAIL_EN
          if (fail_ev) begin
            state_d = ST_DONE;
          end
`endif
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO control, counters and next values of every registered output.
  always_comb begin
    empty  = (wr_q == rd_q);
    full   = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
             (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
    pop    = log_rd && !empty;
    push   = fail_ev && (!full || pop);
    wr_idx = wr_q[IDX_W-1:0];

    wr_d  = wr_q + PTR_W'(push);
    rd_d  = rd_q + PTR_W'(pop);
    cnt_d = fail_cnt;
    ovf_d = overflow;
    halt_d = halt_q;
    if (fail_ev && (fail_cnt != CNT_MAX)) begin
      cnt_d = fail_cnt + CNT_W'(1);
    end
    if (fail_ev && full && !pop) begin
      ovf_d = 1'b1;
    end
    if (fail_ev) begin
      halt_d = 1'b1;
    end
    if (start) begin
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      halt_d = 1'b0;
    end

    empty_d  = (wr_d == rd_d);
    rd_idx_d = rd_d[IDX_W-1:0];

    head_valid_d = !empty_d;
    head_addr_d  = '0;
    head_exp_d   = '0;
    head_act_d   = '0;
    head_gt_d    = 1'b0;
    if (!empty_d) begin
      // New head may be the entry being written this very edge.
      if (push && (rd_idx_d == wr_idx)) begin
        head_addr_d = cmp_addr;
        head_exp_d  = data_t;
        head_act_d  = ramout;
        head_gt_d   = entry_gt;
      end else begin
        head_addr_d = mem_addr[rd_idx_d];
        head_exp_d  = mem_exp[rd_idx_d];
        head_act_d  = mem_act[rd_idx_d];
        head_gt_d   = mem_gt[rd_idx_d];
      end
    end

    busy_d = (state_d == ST_ACTIVE);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (cnt_d == '0) && !ovf_d;
  end

  // Log storage carries no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push && !start) begin
      mem_addr[wr_idx] <= cmp_addr;
      mem_exp[wr_idx]  <= data_t;
      mem_act[wr_idx]  <= ramout;
      mem_gt[wr_idx]   <= entry_gt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      fail_cnt  <= '0;
      overflow  <= 1'b0;
      halt_q    <= 1'b0;
      log_valid <= 1'b0;
      log_addr  <= '0;
      log_exp   <= '0;
      log_act   <= '0;
      log_gt    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      fail_cnt  <= cnt_d;
      overflow  <= ovf_d;
      halt_q    <= halt_d;
      log_valid <= head_valid_d;
      log_addr  <= head_addr_d;
      log_exp   <= head_exp_d;
      log_act   <= head_act_d;
      log_gt    <= head_gt_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
    end
  end

`ifdef BIST_STOP_ON_FAIL_EN
  assign halt_req = halt_q;
`endif

endmodule
